// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding
// and the ID field layout.
package int_controller_pkg;

    localparam int N_SRC_MAX = 31;
    localparam int ID_W      = $clog2(N_SRC_MAX + 1);

    localparam logic [ID_W-1:0] ID_SPURIOUS = 5'h1F;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_MODE = 3'd2;
    localparam logic [2:0] REG_ID   = 3'd3;
    localparam logic [2:0] REG_EOI  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/int_controller_sync.sv
// Per-source input stage: optional 2-flop synchronizer followed by a registered
// copy, giving the clean level and a one-cycle rising-edge pulse.
module int_sync_edge #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic Clk,
    input  logic Clrn,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic w_s;
    logic r_prev;

    if (SYNC_EN) begin : g_sync
        logic r_meta;
        logic r_sync;

        always_ff @(posedge Clk or negedge Clrn) begin
            if (!Clrn) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= i_src;
                r_sync <= r_meta;
            end
        end

        assign w_s = r_sync;
    end else begin : g_nosync
        assign w_s = i_src;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign o_level = w_s;
    assign o_rise  = w_s & ~r_prev;

endmodule

// File: rtl/int_controller.sv
// Memory-mapped interrupt controller: pending/mask/mode registers, fixed priority
// (source 0 highest) and the intr/inta/EOI handshake with the CPU.
//   state   | meaning
//   IDLE    | no request outstanding, intr low
//   REQ     | intr high, waiting for inta
//   SERVICE | handler running, new requests held off until EOI
module int_controller
    import int_controller_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [N_SRC-1:0] irq_src,
    output logic             intr,
    input  logic             inta,
    input  logic             sel,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [N_SRC-1:0] w_s;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  r_id;
    logic             r_svc;
    logic             r_intr;
    logic             w_wr;
    logic             w_any_req;
    logic             w_eoi_wr;
    logic             w_unused_wdata;
    state_t           r_state;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        int_sync_edge #(.SYNC_EN(SYNC_EN)) u_sync (
            .Clk     (Clk),
            .Clrn    (Clrn),
            .i_src   (irq_src[g]),
            .o_level (w_s[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_wr           = sel & we;
    assign w_eoi_wr       = w_wr && (addr == REG_EOI);
    assign w_w1c          = (w_wr && (addr == REG_PEND)) ? wdata[N_SRC-1:0] : '0;
    assign w_req          = r_pend & r_mask;
    assign w_any_req      = |w_req;
    assign w_unused_wdata = ^wdata[31:N_SRC];

    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) w_win = ID_W'(i);
        end
    end

    // Only an acknowledged edge-mode winner is cleared; level bits follow the line.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_ack_clr[i] = (r_state == ST_REQ) && inta && w_any_req &&
                           (w_win == ID_W'(i)) && r_mode[i];
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_mode & (w_rise | (r_pend & ~(w_w1c | w_ack_clr)))) |
                      (~r_mode & w_s);
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_mask <= '0;
            r_mode <= '0;
        end else begin
            if (w_wr && (addr == REG_MASK)) r_mask <= wdata[N_SRC-1:0];
            if (w_wr && (addr == REG_MODE)) r_mode <= wdata[N_SRC-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_state <= ST_IDLE;
            r_intr  <= 1'b0;
            r_svc   <= 1'b0;
            r_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_REQ;
                        r_intr  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (inta) begin
                        r_state <= ST_SERVICE;
                        r_intr  <= 1'b0;
                        r_svc   <= 1'b1;
                        r_id    <= w_any_req ? w_win : ID_SPURIOUS;
                    end else if (!w_any_req) begin
                        r_state <= ST_IDLE;
                        r_intr  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi_wr) begin
                        r_state <= ST_IDLE;
                        r_svc   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign intr = r_intr;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                REG_PEND: rdata = 32'(r_pend);
                REG_MASK: rdata = 32'(r_mask);
                REG_MODE: rdata = 32'(r_mode);
                REG_ID:   rdata = {r_svc, {(31 - ID_W){1'b0}}, r_id};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: stimulus pushes expected observations into a
// scoreboard, a negedge monitor pops and compares them.
module tb_int_controller;

    localparam int N = 8;

    logic         Clk = 1'b0;
    logic         Clrn = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic         intr;
    logic         inta = 1'b0;
    logic         sel = 1'b0;
    logic [2:0]   addr = '0;
    logic         we = 1'b0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;

    int checks = 0;
    int errors = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];
    bit          kind_q[$];
    bit          mon_vld = 1'b0;

    always #5 Clk = ~Clk;

    int_controller #(.N_SRC(N), .SYNC_EN(1'b1)) dut (
        .Clk     (Clk),
        .Clrn    (Clrn),
        .irq_src (irq_src),
        .intr    (intr),
        .inta    (inta),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    // kind 0 = bus read data, kind 1 = intr line
    always @(negedge Clk) begin
        string       nm;
        logic [31:0] ex;
        logic [31:0] got;
        bit          k;
        if (mon_vld) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                nm  = name_q.pop_front();
                ex  = exp_q.pop_front();
                k   = kind_q.pop_front();
                got = k ? {31'd0, intr} : rdata;
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", nm, got, ex);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input string nm, input logic [31:0] ex, input bit k);
        name_q.push_back(nm);
        exp_q.push_back(ex);
        kind_q.push_back(k);
    endtask

    task automatic wr(input logic s, input logic [2:0] a, input logic [31:0] d);
        sel = s; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic rd_chk(input logic s, input logic [2:0] a, input logic [31:0] ex,
                          input string nm);
        sel = s; we = 1'b0; addr = a;
        push(nm, ex, 1'b0);
        mon_vld = 1'b1;
        tick();
        mon_vld = 1'b0; sel = 1'b0;
    endtask

    task automatic intr_chk(input logic ex, input string nm);
        push(nm, {31'd0, ex}, 1'b1);
        mon_vld = 1'b1;
        tick();
        mon_vld = 1'b0;
    endtask

    task automatic ack(input int n);
        inta = 1'b1;
        ticks(n);
        inta = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        ticks(3);
        Clrn = 1'b1;
        tick();

        for (int a = 0; a < 8; a++) rd_chk(1'b1, 3'(a), 32'h0, $sformatf("rst_reg%0d", a));

        // single edge source
        wr(1'b1, 3'd1, 32'h04);
        wr(1'b1, 3'd2, 32'h04);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        ticks(2);
        intr_chk(1'b0, "edge_lat3");
        intr_chk(1'b1, "edge_lat4");
        ack(1);
        intr_chk(1'b0, "ack_intr");
        rd_chk(1'b1, 3'd3, 32'h8000_0002, "ack_id");
        rd_chk(1'b1, 3'd0, 32'h0, "ack_pend");
        wr(1'b1, 3'd4, 32'h0);
        rd_chk(1'b1, 3'd3, 32'h0000_0002, "eoi_id");

        // priority, held inta, no nesting
        wr(1'b1, 3'd1, 32'hFF);
        wr(1'b1, 3'd2, 32'hFF);
        irq_src = 8'h22;
        ticks(4);
        intr_chk(1'b1, "prio_intr");
        ack(3);
        rd_chk(1'b1, 3'd3, 32'h8000_0001, "prio_id");
        rd_chk(1'b1, 3'd0, 32'h20, "prio_pend5");
        intr_chk(1'b0, "nonest_intr");
        wr(1'b1, 3'd4, 32'h0);
        intr_chk(1'b0, "eoi_gap");
        intr_chk(1'b1, "reraise");
        ack(1);
        rd_chk(1'b1, 3'd3, 32'h8000_0005, "second_id");
        irq_src = 8'h00;
        wr(1'b1, 3'd4, 32'h0);

        // level withdrawal, then a late inta
        wr(1'b1, 3'd2, 32'h00);
        irq_src = 8'h08;
        ticks(4);
        intr_chk(1'b1, "lvl_intr");
        irq_src = 8'h00;
        ticks(3);
        intr_chk(1'b1, "lvl_hold");
        intr_chk(1'b0, "lvl_withdraw");
        irq_src = 8'h08;
        ticks(4);
        intr_chk(1'b1, "late_req");
        irq_src = 8'h00;
        ticks(3);
        ack(1);
        rd_chk(1'b1, 3'd3, 32'h8000_001F, "spurious_id");
        wr(1'b1, 3'd4, 32'h0);
        rd_chk(1'b1, 3'd3, 32'h0000_001F, "spurious_eoi");

        // masking and W1C
        wr(1'b1, 3'd2, 32'h40);
        wr(1'b1, 3'd1, 32'h00);
        irq_src = 8'h40;
        ticks(4);
        rd_chk(1'b1, 3'd0, 32'h40, "masked_pend");
        intr_chk(1'b0, "masked_intr");
        wr(1'b1, 3'd1, 32'h40);
        tick();
        intr_chk(1'b1, "unmask_intr");
        ack(1);
        rd_chk(1'b1, 3'd3, 32'h8000_0006, "unmask_id");
        irq_src = 8'h00;
        wr(1'b1, 3'd4, 32'h0);
        wr(1'b1, 3'd1, 32'h00);
        ticks(3);
        irq_src = 8'h40;
        ticks(2);
        wr(1'b1, 3'd0, 32'h40);
        rd_chk(1'b1, 3'd0, 32'h40, "w1c_vs_edge");
        wr(1'b1, 3'd0, 32'h40);
        rd_chk(1'b1, 3'd0, 32'h00, "w1c_clear");

        // bus decode
        wr(1'b1, 3'd1, 32'hA5);
        rd_chk(1'b1, 3'd1, 32'hA5, "mask_rw");
        wr(1'b0, 3'd1, 32'h5A);
        rd_chk(1'b1, 3'd1, 32'hA5, "sel0_wr");
        rd_chk(1'b0, 3'd1, 32'h0, "sel0_rdata");
        rd_chk(1'b1, 3'd2, 32'h40, "mode_rw");
        wr(1'b1, 3'd5, 32'hFFFF_FFFF);
        for (int a = 5; a < 8; a++) rd_chk(1'b1, 3'(a), 32'h0, $sformatf("unmapped%0d", a));

        // asynchronous reset while in REQ
        irq_src = 8'h00;
        ticks(3);
        wr(1'b1, 3'd2, 32'h00);
        wr(1'b1, 3'd1, 32'hFF);
        irq_src = 8'h01;
        ticks(4);
        intr_chk(1'b1, "pre_rst");
        Clrn = 1'b0;
        intr_chk(1'b0, "rst_async");
        irq_src = 8'h00;
        Clrn = 1'b1;
        for (int a = 0; a < 5; a++) rd_chk(1'b1, 3'(a), 32'h0, $sformatf("post_rst%0d", a));

        ticks(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
